ad9434_lane_align: RTL

Parametrised capture back-end for AD9434-class DDR LVDS ADCs. It reassembles per-channel rising/falling IDDR half-words into full samples and runs a training sequencer. The sequencer sweeps the external VAR_LOAD IDELAY taps, finds the widest passing eye and edge order per channel, and applies the centre tap. It sits between the IDDR/IDELAYE2 capture primitives and downstream sample consumers (FIFO/ILA), entirely in the ADC DCO clock domain.

---
 rtl/ad9434_lane_align.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ad9434_lane_align.sv
// DDR half-word reassembly and IDELAY eye-training sequencer for AD9434-class LVDS ADCs.
// Define AD9434_ALIGN_OR_EN to register over-range flags alongside the samples.
module ad9434_lane_align #(
  parameter int unsigned         NUM_CH     = 1,
  parameter int unsigned         HALF_W     = 6,
  parameter int unsigned         TAP_W      = 5,
  parameter int unsigned         SETTLE_CYC = 16,
  parameter int unsigned         CHECK_CYC  = 64,
  parameter logic [2*HALF_W-1:0] TRAIN_PAT  = 12'hA5C
) (
  input  logic                       adc_clk,
  input  logic                       rst,
  input  logic                       train_start,
  input  logic [NUM_CH*HALF_W-1:0]   d_rise,
  input  logic [NUM_CH*HALF_W-1:0]   d_fall,
  input  logic [NUM_CH-1:0]          or_in,
  output logic [NUM_CH*TAP_W-1:0]    tap_val,
  output logic [NUM_CH-1:0]          tap_ld,
  output logic [NUM_CH*2*HALF_W-1:0] sample_out,
  output logic [NUM_CH-1:0]          or_out,
  output logic                       sample_valid,
  output logic                       train_busy,
  output logic                       train_done,
  output logic [NUM_CH-1:0]          train_err
);
  localparam int unsigned SW      = 2 * HALF_W;
  localparam int unsigned LEN_W   = TAP_W + 1;
  localparam int unsigned CNT_MAX = (SETTLE_CYC > CHECK_CYC) ? SETTLE_CYC : CHECK_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] STEP   = 3'd4;
  localparam logic [2:0] APPLY  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [TAP_W-1:0]  t_q, t_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic [NUM_CH-1:0] tap_ld_q, tap_ld_d, err_q, err_d, swap_q, swap_d;
  logic [NUM_CH-1:0] pass_n_q, pass_n_d, pass_s_q, pass_s_d;
  logic [NUM_CH-1:0] run_ord_q, run_ord_d, best_ord_q, best_ord_d;
  logic [TAP_W-1:0]  tap_q [NUM_CH];
  logic [TAP_W-1:0]  tap_d [NUM_CH];
  logic [TAP_W-1:0]  run_start_q [NUM_CH];
  logic [TAP_W-1:0]  run_start_d [NUM_CH];
  logic [TAP_W-1:0]  best_start_q [NUM_CH];
  logic [TAP_W-1:0]  best_start_d [NUM_CH];
  logic [LEN_W-1:0]  run_len_q [NUM_CH];
  logic [LEN_W-1:0]  run_len_d [NUM_CH];
  logic [LEN_W-1:0]  best_len_q [NUM_CH];
  logic [LEN_W-1:0]  best_len_d [NUM_CH];
  logic [HALF_W-1:0] fall_d1_q [NUM_CH];
  logic [SW-1:0]     sample_q [NUM_CH];

  logic [NUM_CH-1:0] match_n_c, match_s_c, cand_ord_c;
  logic [TAP_W-1:0]  cand_start_c [NUM_CH];
  logic [LEN_W-1:0]  cand_len_c [NUM_CH];

  // Pattern match of both word orders and the run a tap would produce in STEP.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      match_n_c[c]    = ({d_rise[c*HALF_W +: HALF_W], d_fall[c*HALF_W +: HALF_W]} == TRAIN_PAT);
      match_s_c[c]    = ({fall_d1_q[c], d_rise[c*HALF_W +: HALF_W]} == TRAIN_PAT);
      cand_ord_c[c]   = ~pass_n_q[c];
      cand_start_c[c] = t_q;
      cand_len_c[c]   = '0;
      if (pass_n_q[c] | pass_s_q[c]) begin
        if ((run_len_q[c] != '0) && (run_ord_q[c] == cand_ord_c[c])) begin
          cand_start_c[c] = run_start_q[c];
          cand_len_c[c]   = run_len_q[c] + LEN_W'(1);
        end else begin
          cand_len_c[c] = LEN_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    err_d      = err_q;
    swap_d     = swap_q;
    pass_n_d   = pass_n_q;
    pass_s_d   = pass_s_q;
    run_ord_d  = run_ord_q;
    best_ord_d = best_ord_q;
    for (int c = 0; c < NUM_CH; c++) begin
      tap_d[c]        = tap_q[c];
      run_start_d[c]  = run_start_q[c];
      run_len_d[c]    = run_len_q[c];
      best_start_d[c] = best_start_q[c];
      best_len_d[c]   = best_len_q[c];
    end

    case (state_q)
      IDLE: begin
        if (train_start) begin
          state_d    = LOAD;
          t_d        = '0;
          done_d     = 1'b0;
          err_d      = '0;
          run_ord_d  = '0;
          best_ord_d = '0;
          for (int c = 0; c < NUM_CH; c++) begin
            run_start_d[c]  = '0;
            run_len_d[c]    = '0;
            best_start_d[c] = '0;
            best_len_d[c]   = '0;
          end
        end
      end
      LOAD: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          state_d  = CHECK;
          cnt_d    = '0;
          pass_n_d = '1;
          pass_s_d = '1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CHECK: begin
        pass_n_d = pass_n_q & match_n_c;
        pass_s_d = pass_s_q & match_s_c;
        if (cnt_q == CNT_W'(CHECK_CYC - 1)) begin
          state_d = STEP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STEP: begin
        run_ord_d = cand_ord_c;
        for (int c = 0; c < NUM_CH; c++) begin
          run_start_d[c] = cand_start_c[c];
          run_len_d[c]   = cand_len_c[c];
          // Strictly greater keeps the earliest of equally wide eyes.
          if (cand_len_c[c] > best_len_q[c]) begin
            best_start_d[c] = cand_start_c[c];
            best_len_d[c]   = cand_len_c[c];
            best_ord_d[c]   = cand_ord_c[c];
          end
        end
        if (&t_q) begin
          state_d = APPLY;
        end else begin
          state_d = LOAD;
          t_d     = t_q + TAP_W'(1);
        end
      end
      APPLY: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d != IDLE);
    valid_d  = done_d && (state_d == IDLE);
    tap_ld_d = ((state_d == LOAD) || (state_d == APPLY)) ? '1 : '0;

    // Tap/order programming is computed on entry so it lands with tap_ld.
    for (int c = 0; c < NUM_CH; c++) begin
      if (state_d == LOAD) begin
        tap_d[c] = t_d;
      end else if ((state_q == STEP) && (state_d == APPLY)) begin
        if (best_len_d[c] == '0) begin
          tap_d[c]  = '0;
          swap_d[c] = 1'b0;
          err_d[c]  = 1'b1;
        end else begin
          tap_d[c]  = best_start_d[c] + TAP_W'(best_len_d[c] >> 1);
          swap_d[c] = best_ord_d[c];
        end
      end
    end
  end

  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      t_q        <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      tap_ld_q   <= '0;
      err_q      <= '0;
      swap_q     <= '0;
      pass_n_q   <= '0;
      pass_s_q   <= '0;
      run_ord_q  <= '0;
      best_ord_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        tap_q[c]        <= '0;
        run_start_q[c]  <= '0;
        run_len_q[c]    <= '0;
        best_start_q[c] <= '0;
        best_len_q[c]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      tap_ld_q   <= tap_ld_d;
      err_q      <= err_d;
      swap_q     <= swap_d;
      pass_n_q   <= pass_n_d;
      pass_s_q   <= pass_s_d;
      run_ord_q  <= run_ord_d;
      best_ord_q <= best_ord_d;
      for (int c = 0; c < NUM_CH; c++) begin
        tap_q[c]        <= tap_d[c];
        run_start_q[c]  <= run_start_d[c];
        run_len_q[c]    <= run_len_d[c];
        best_start_q[c] <= best_start_d[c];
        best_len_q[c]   <= best_len_d[c];
      end
    end
  end

  // Sample assembly: swapped order pairs last cycle's falling half with this rising half.
  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        fall_d1_q[c] <= '0;
        sample_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        fall_d1_q[c] <= d_fall[c*HALF_W +: HALF_W];
        sample_q[c]  <= swap_q[c] ? {fall_d1_q[c], d_rise[c*HALF_W +: HALF_W]}
                                  : {d_rise[c*HALF_W +: HALF_W], d_fall[c*HALF_W +: HALF_W]};
      end
    end
  end

`ifdef AD9434_ALIGN_OR_EN
  logic [NUM_CH-1:0] or_q;

  // Both orders take the flag of the rising-half cycle, i.e. the current one.
  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) or_q <= '0;
    else     or_q <= or_in;
  end

  assign or_out = or_q;
`else
  logic unused_or_in_c;

  assign unused_or_in_c = ^or_in;
  assign or_out         = '0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign tap_val[c*TAP_W +: TAP_W] = tap_q[c];
    assign sample_out[c*SW +: SW]    = sample_q[c];
  end

  assign tap_ld       = tap_ld_q;
  assign sample_valid = valid_q;
  assign train_busy   = busy_q;
  assign train_done   = done_q;
  assign train_err    = err_q;

endmodule
